// File: rtl/program_loader_pkg.sv
// Shared constants for the serial program loader: state encodings, header width
// and default word geometry.
package program_loader_pkg;

  localparam int DEFAULT_WORD_BYTES = 4;
  localparam int LEN_WIDTH          = 16;
  localparam int ADDR_WIDTH         = 32;
  localparam int WORD_WIDTH         = 32;

  // Fixed encodings so the state register stays readable in waveform viewers of older flows
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_HI = 3'd1;
  localparam logic [2:0] ST_LEN_LO = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERROR  = 3'd6;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write port of the loader.
// master = byte source / memory side, slave = loader.
interface program_loader_if;
  import program_loader_pkg::*;

  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_WIDTH-1:0] mem_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/program_loader_word_assembler.sv
// Packs incoming bytes big-endian into 32-bit words; pulses word_valid for one
// cycle after the fourth byte of each word is taken.
module word_assembler
  import program_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  word_valid,
  output logic [WORD_WIDTH-1:0] word_data,
  output logic [1:0]            byte_count
);

  // word_data doubles as the shift register, so it holds the finished word during the pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_count <= 2'd0;
      word_data  <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= byte_valid && (byte_count == 2'd3);
      if (clear) begin
        byte_count <= 2'd0;
      end else if (byte_valid) begin
        byte_count <= byte_count + 2'd1;
        word_data  <= {word_data[WORD_WIDTH-9:0], byte_data};
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed program image from a byte stream into program memory
// while holding the CPU in reset. Optional trailing checksum: PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int MEMORY_DEPTH = 64,
  parameter int WORD_BYTES   = DEFAULT_WORD_BYTES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  program_loader_if.slave      bus,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 error,
  output logic [LEN_WIDTH-1:0] words_loaded
);

  logic [2:0]            state;
  logic [7:0]            len_hi;
  logic [LEN_WIDTH-1:0]  frame_len;
  logic [LEN_WIDTH-1:0]  len_word;
  logic [LEN_WIDTH-1:0]  next_count;
  logic                  accept;
  logic                  data_accept;
  logic                  restart;
  logic                  len_bad;
  logic                  word_valid;
  logic [1:0]            byte_count;
  logic [WORD_WIDTH-1:0] word_data;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]            checksum;
`endif

  assign accept      = bus.rx_valid && bus.rx_ready;
  assign data_accept = accept && (state == ST_DATA);
  assign restart     = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
  assign len_word    = {len_hi, bus.rx_data};
  assign next_count  = words_loaded + 16'd1;
  assign len_bad     = (len_word == '0) || (32'(len_word) > 32'(MEMORY_DEPTH));

  assign bus.rx_ready  = (state == ST_LEN_HI) || (state == ST_LEN_LO) ||
                         (state == ST_DATA)   || (state == ST_CHECK);
  assign bus.mem_we    = word_valid;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = word_data;

  assign cpu_hold = (state != ST_DONE);
  assign done     = (state == ST_DONE);
  assign error    = (state == ST_ERROR);

  word_assembler u_word_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear      (restart),
    .byte_valid (data_accept),
    .byte_data  (bus.rx_data),
    .word_valid (word_valid),
    .word_data  (word_data),
    .byte_count (byte_count)
  );

  // Address and count advance on the edge that takes the last byte of a word,
  // so they line up with the write pulse the assembler produces in the next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      len_hi       <= 8'd0;
      frame_len    <= '0;
      words_loaded <= '0;
      mem_addr_q   <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      checksum     <= 8'd0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state        <= ST_LEN_HI;
            words_loaded <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            checksum     <= 8'd0;
`endif
          end
        end
        ST_LEN_HI: begin
          if (accept) begin
            len_hi <= bus.rx_data;
            state  <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (accept) begin
            frame_len <= len_word;
            state     <= len_bad ? ST_ERROR : ST_DATA;
          end
        end
        ST_DATA: begin
          if (accept) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            checksum <= checksum ^ bus.rx_data;
`endif
            if (byte_count == 2'd3) begin
              words_loaded <= next_count;
              mem_addr_q   <= ADDR_WIDTH'(words_loaded) * ADDR_WIDTH'(WORD_BYTES);
              if (next_count == frame_len) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                state <= ST_CHECK;
`else
                state <= ST_DONE;
`endif
              end
            end
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (accept) begin
            state <= (bus.rx_data == checksum) ? ST_DONE : ST_ERROR;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
